// File: rtl/id_stage_hazard.sv
// RV32I/RV32E decode stage: decoder, register file, immediates, load-use hazard unit, ID/EX register.
// Optional: define ID_RF_BYPASS_EN for write-through register-file reads instead of a WB-collision stall.
module id_stage_hazard #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_alusrc,
    output logic [1:0]      ex_aluop,
    output logic            ex_branch,
    output logic            ex_jump,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_regwrite
);

    localparam int AW = $clog2(NUM_REGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [XLEN-1:0] regs [NUM_REGS];

    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd;
    logic            legal_op, use_rs1, use_rs2, use_rd, is_lui, illegal;
    logic            dec_alusrc, dec_branch, dec_jump, dec_memread, dec_memwrite;
    logic            dec_memtoreg, dec_regwrite;
    logic [1:0]      dec_aluop;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            load_use, wb_hit, issue;

    function automatic logic in_range(input logic [4:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    assign opcode = if_instr[6:0];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rd     = if_instr[11:7];

    // Opcode decode, immediate formation and which register fields this opcode actually uses.
    always_comb begin
        legal_op     = 1'b1;
        use_rs1      = 1'b0;
        use_rs2      = 1'b0;
        use_rd       = 1'b0;
        is_lui       = 1'b0;
        dec_alusrc   = 1'b0;
        dec_aluop    = 2'b00;
        dec_branch   = 1'b0;
        dec_jump     = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_regwrite = 1'b0;
        dec_imm      = '0;
        case (opcode)
            OP_R: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                dec_aluop = 2'b10; dec_regwrite = 1'b1;
            end
            OP_IALU: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec_aluop = 2'b11; dec_alusrc = 1'b1; dec_regwrite = 1'b1;
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OP_LOAD: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec_alusrc = 1'b1; dec_memread = 1'b1; dec_memtoreg = 1'b1; dec_regwrite = 1'b1;
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            OP_STORE: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_alusrc = 1'b1; dec_memwrite = 1'b1;
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            end
            OP_BRANCH: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                dec_aluop = 2'b01; dec_branch = 1'b1;
                dec_imm = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                           if_instr[30:25], if_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                use_rd = 1'b1; is_lui = (opcode == OP_LUI);
                dec_alusrc = 1'b1; dec_regwrite = 1'b1;
                dec_imm = {{(XLEN-32){if_instr[31]}}, if_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                dec_jump = 1'b1; dec_regwrite = 1'b1;
                dec_imm = {{(XLEN-21){if_instr[31]}}, if_instr[31], if_instr[19:12],
                           if_instr[20], if_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                use_rs1 = 1'b1; use_rd = 1'b1;
                dec_jump = 1'b1; dec_alusrc = 1'b1; dec_regwrite = 1'b1;
                dec_imm = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
            end
            default: legal_op = 1'b0;
        endcase
    end

    assign illegal = ~legal_op | (if_instr[1:0] != 2'b11)
                   | (use_rs1 & ~in_range(rs1)) | (use_rs2 & ~in_range(rs2))
                   | (use_rd & ~in_range(rd));

    // Register file reads; out-of-range indices read as zero since such instructions never issue.
    always_comb begin
        rs1_val = (rs1 == 5'd0 || !in_range(rs1)) ? '0 : regs[rs1[AW-1:0]];
        rs2_val = (rs2 == 5'd0 || !in_range(rs2)) ? '0 : regs[rs2[AW-1:0]];
`ifdef ID_RF_BYPASS_EN
        if (wb_we && wb_rd != 5'd0 && wb_rd == rs1) rs1_val = wb_data;
        if (wb_we && wb_rd != 5'd0 && wb_rd == rs2) rs2_val = wb_data;
`endif
    end

    // Write port: x0 and indices beyond the file depth are never written.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_we && wb_rd != 5'd0 && in_range(wb_rd)) begin
            regs[wb_rd[AW-1:0]] <= wb_data;
        end
    end

    assign load_use = if_valid & ex_valid & ex_memread & (ex_rd != 5'd0)
                    & ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

`ifdef ID_RF_BYPASS_EN
    assign wb_hit = 1'b0;
`else
    // Without bypass a read colliding with this cycle's write would see stale data, so wait a cycle.
    assign wb_hit = if_valid & wb_we & (wb_rd != 5'd0)
                  & ((use_rs1 & (rs1 == wb_rd)) | (use_rs2 & (rs2 == wb_rd)));
`endif

    assign id_stall = (load_use | wb_hit) & ~flush;
    assign issue    = if_valid & ~illegal & ~flush & ~id_stall;

    // ID/EX register: anything that does not issue becomes an all-zero bubble.
    always_ff @(posedge clock) begin
        if (reset || !issue) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_alusrc   <= 1'b0;
            ex_aluop    <= '0;
            ex_branch   <= 1'b0;
            ex_jump     <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_regwrite <= 1'b0;
        end else begin
            ex_valid    <= 1'b1;
            ex_pc       <= if_pc;
            ex_rs1_data <= is_lui ? '0 : rs1_val;
            ex_rs2_data <= rs2_val;
            ex_imm      <= dec_imm;
            ex_rs1      <= is_lui ? 5'd0 : rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            ex_funct3   <= if_instr[14:12];
            ex_funct7b5 <= if_instr[30];
            ex_alusrc   <= dec_alusrc;
            ex_aluop    <= dec_aluop;
            ex_branch   <= dec_branch;
            ex_jump     <= dec_jump;
            ex_memread  <= dec_memread;
            ex_memwrite <= dec_memwrite;
            ex_memtoreg <= dec_memtoreg;
            ex_regwrite <= dec_regwrite;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: directed vectors push the expected id_stall and ID/EX
// contents observed each cycle; a monitor pops and compares them on the falling edge.
module tb_id_stage_hazard;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        f7;
        logic [8:0]  ctrl;
    } ex_t;

    typedef struct packed {
        logic stall;
        ex_t  ex;
    } exp_t;

    // Control bundle order: alusrc, aluop[1:0], branch, jump, memread, memwrite, memtoreg, regwrite
    localparam logic [8:0] C_R     = 9'b0_10_0_0_0_0_0_1;
    localparam logic [8:0] C_I     = 9'b1_11_0_0_0_0_0_1;
    localparam logic [8:0] C_LOAD  = 9'b1_00_0_0_1_0_1_1;
    localparam logic [8:0] C_STORE = 9'b1_00_0_0_0_1_0_0;
    localparam logic [8:0] C_BR    = 9'b0_01_1_0_0_0_0_0;
    localparam logic [8:0] C_LUI   = 9'b1_00_0_0_0_0_0_1;
    localparam logic [8:0] C_JAL   = 9'b0_00_0_1_0_0_0_1;
    localparam ex_t        BUBBLE  = '0;

    logic        clock = 1'b0;
    logic        reset, if_valid, flush, wb_we;
    logic [31:0] if_instr, if_pc, wb_data;
    logic [4:0]  wb_rd;
    logic        id_stall, ex_valid, ex_funct7b5, ex_alusrc, ex_branch, ex_jump;
    logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_aluop;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    id_stage_hazard #(.XLEN(32), .NUM_REGS(32)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite)
    );

    always #5 clock = ~clock;

    function automatic ex_t mk(input logic [31:0] pc, d1, d2, imm, input logic [4:0] rs1, rs2, rd,
                               input logic [2:0] f3, input logic f7, input logic [8:0] ctrl);
        return '{valid: 1'b1, pc: pc, d1: d1, d2: d2, imm: imm, rs1: rs1, rs2: rs2, rd: rd,
                 f3: f3, f7: f7, ctrl: ctrl};
    endfunction

    // Drives one cycle of inputs and records what should be seen on the falling edge of that cycle.
    task automatic applyStimulus(input logic rst, iv, input logic [31:0] instr, pc, input logic fl,
                                 input logic we, input logic [4:0] wrd, input logic [31:0] wdata,
                                 input logic stall_exp, input ex_t ex_exp);
        @(posedge clock);
        #1;
        reset    = rst;
        if_valid = iv;
        if_instr = instr;
        if_pc    = pc;
        flush    = fl;
        wb_we    = we;
        wb_rd    = wrd;
        wb_data  = wdata;
        sb.push_back('{stall: stall_exp, ex: ex_exp});
    endtask

    task automatic issueInstr(input logic [31:0] instr, pc, input logic fl, input logic stall_exp,
                              input ex_t ex_exp);
        applyStimulus(1'b0, 1'b1, instr, pc, fl, 1'b0, 5'd0, 32'h0, stall_exp, ex_exp);
    endtask

    task automatic idle(input ex_t ex_exp);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, ex_exp);
    endtask

    task automatic checkOutput(input exp_t e);
        ex_t act;
        act = '{valid: ex_valid, pc: ex_pc, d1: ex_rs1_data, d2: ex_rs2_data, imm: ex_imm,
                rs1: ex_rs1, rs2: ex_rs2, rd: ex_rd, f3: ex_funct3, f7: ex_funct7b5,
                ctrl: {ex_alusrc, ex_aluop, ex_branch, ex_jump, ex_memread, ex_memwrite,
                       ex_memtoreg, ex_regwrite}};
        compared++;
        if (id_stall !== e.stall) begin
            mismatched++;
            $display("[TB] FAIL id_stall @%0t: got %b expected %b", $time, id_stall, e.stall);
        end
        compared++;
        if (act !== e.ex) begin
            mismatched++;
            $display("[TB] FAIL id_ex @%0t: got %h expected %h", $time, act, e.ex);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ex_t add_x6, lw_x7, add_x8, addi_x10;
        reset = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
        flush = 1'b0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;

        lw_x7  = mk(32'h108, 0, 0, 0, 5'd1, 5'd0, 5'd7, 3'd2, 1'b0, C_LOAD);
        add_x8 = mk(32'h10C, 0, 0, 0, 5'd7, 5'd2, 5'd8, 3'd0, 1'b0, C_R);

        // Reset for two cycles, then read high registers to confirm they cleared
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, BUBBLE);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, BUBBLE);
        issueInstr(32'h01EFE533, 32'h100, 1'b0, 1'b0, BUBBLE);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0,
                      mk(32'h100, 0, 0, 0, 5'd31, 5'd30, 5'd10, 3'd6, 1'b0, C_R));

        // add x6,x5,x5 after x5 was written
        add_x6 = mk(32'h104, 32'hDEADBEEF, 32'hDEADBEEF, 0, 5'd5, 5'd5, 5'd6, 3'd0, 1'b0, C_R);
        issueInstr(32'h00528333, 32'h104, 1'b0, 1'b0, BUBBLE);

        // Load-use: lw x7 then add x8,x7,x2 stalls once
        issueInstr(32'h0000A383, 32'h108, 1'b0, 1'b0, add_x6);
        issueInstr(32'h00238433, 32'h10C, 1'b0, 1'b1, lw_x7);
        issueInstr(32'h00238433, 32'h10C, 1'b0, 1'b0, BUBBLE);
        idle(add_x8);

        // Same hazard with flush in the stall cycle: no stall, bubble
        lw_x7.pc = 32'h110;
        issueInstr(32'h0000A383, 32'h110, 1'b0, 1'b0, BUBBLE);
        issueInstr(32'h00238433, 32'h114, 1'b1, 1'b0, lw_x7);
        idle(BUBBLE);

        // Branch and store immediates
        issueInstr(32'hFE000EE3, 32'h200, 1'b0, 1'b0, BUBBLE);
        issueInstr(32'h0020A423, 32'h204, 1'b0, 1'b0,
                   mk(32'h200, 0, 0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd29, 3'd0, 1'b1, C_BR));
        idle(mk(32'h204, 0, 0, 32'h8, 5'd1, 5'd2, 5'd8, 3'd2, 1'b0, C_STORE));

        // Same-cycle writeback of x9 while addi x10,x9,1 decodes
        addi_x10 = mk(32'h300, 32'h12345678, 0, 32'h1, 5'd9, 5'd1, 5'd10, 3'd0, 1'b0, C_I);
`ifdef ID_RF_BYPASS_EN
        applyStimulus(1'b0, 1'b1, 32'h00148513, 32'h300, 1'b0, 1'b1, 5'd9, 32'h12345678, 1'b0,
                      BUBBLE);
        idle(addi_x10);
        idle(BUBBLE);
`else
        applyStimulus(1'b0, 1'b1, 32'h00148513, 32'h300, 1'b0, 1'b1, 5'd9, 32'h12345678, 1'b1,
                      BUBBLE);
        issueInstr(32'h00148513, 32'h300, 1'b0, 1'b0, BUBBLE);
        idle(addi_x10);
`endif

        // A write to x0 is ignored; add x11,x0,x9 reads 0 and the retained x9
        applyStimulus(1'b0, 1'b1, 32'h009005B3, 32'h310, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0,
                      BUBBLE);
        idle(mk(32'h310, 0, 32'h12345678, 0, 5'd0, 5'd9, 5'd11, 3'd0, 1'b0, C_R));
        idle(BUBBLE);

        // LUI forces rs1 to zero even though its field names x5; then JAL; then an illegal word
        issueInstr(32'h80028637, 32'h400, 1'b0, 1'b0, BUBBLE);
        issueInstr(32'h008000EF, 32'h404, 1'b0, 1'b0,
                   mk(32'h400, 0, 0, 32'h80028000, 5'd0, 5'd0, 5'd12, 3'd0, 1'b0, C_LUI));
        issueInstr(32'h00000000, 32'h408, 1'b0, 1'b0,
                   mk(32'h404, 0, 0, 32'h8, 5'd0, 5'd8, 5'd1, 3'd0, 1'b0, C_JAL));
        idle(BUBBLE);

        // Reset mid-operation clears ID/EX and the register file
        issueInstr(32'h00528333, 32'h500, 1'b0, 1'b0, BUBBLE);
        add_x6.pc = 32'h500;
        applyStimulus(1'b1, 1'b1, 32'h00528333, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, add_x6);
        idle(BUBBLE);
        issueInstr(32'h00528333, 32'h504, 1'b0, 1'b0, BUBBLE);
        idle(mk(32'h504, 0, 0, 0, 5'd5, 5'd5, 5'd6, 3'd0, 1'b0, C_R));

        @(posedge clock);
        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
